// File: rtl/dbg_step_ctrl.sv
// dbg_step_ctrl: button-driven HALT/STEP/BURST/RUN controller gating the CPU pipeline enable.
// Ports: i_clk/i_rst (sync, active high); i_btn_step/i_btn_mode raw bouncy buttons;
//   i_burst_len burst length (0 acts as 1); o_cpu_enable registered pipeline enable;
//   o_mode 0=HALT 1=STEP 2=BURST 3=RUN; o_busy burst running; o_paused RUN paused;
//   o_cycle_count number of enabled cycles (wrapping).
module dbg_step_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BURST_W = 8,
  parameter int CNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_btn_step,
  input  logic               i_btn_mode,
  input  logic [BURST_W-1:0] i_burst_len,
  output logic               o_cpu_enable,
  output logic [1:0]         o_mode,
  output logic               o_busy,
  output logic               o_paused,
  output logic [CNT_W-1:0]   o_cycle_count
);
  typedef enum logic [1:0] {HALT, STEP, BURST, RUN} mode_t;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] raw, press;
  assign raw = {i_btn_mode, i_btn_step};
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0] cnt;
    logic db, db_q, pulse;
    logic differ;
    assign differ = sync[SYNC_STAGES-1] != db;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        sync <= '0;
        cnt <= '0;
        db <= 1'b0;
        db_q <= 1'b0;
        pulse <= 1'b0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], raw[b]};
        cnt <= (!differ || cnt == DB_LAST) ? '0 : cnt + 1'b1;
        db <= (differ && cnt == DB_LAST) ? sync[SYNC_STAGES-1] : db;
        db_q <= db;
        pulse <= db & ~db_q;
      end
    end
    assign press[b] = pulse;
  end
  mode_t mode, mode_n;
  logic en, en_n, busy, busy_n, paused, paused_n;
  logic [BURST_W-1:0] rem, rem_n, len_eff;
  logic [CNT_W-1:0] count;
  assign len_eff = (i_burst_len == '0) ? BURST_W'(1) : i_burst_len;
  // rem counts enabled cycles still owed after the current one
  always_comb begin
    mode_n = mode;
    busy_n = busy;
    paused_n = paused;
    rem_n = rem;
    en_n = 1'b0;
    if (press[1]) begin
      mode_n = mode_t'(mode + 2'd1);
      busy_n = 1'b0;
      paused_n = 1'b0;
    end else if (busy) begin
      busy_n = rem != '0;
      en_n = rem != '0;
      rem_n = (rem != '0) ? rem - 1'b1 : rem;
    end else if (press[0]) begin
      en_n = mode == STEP || mode == BURST;
      busy_n = mode == BURST;
      rem_n = (mode == BURST) ? len_eff - 1'b1 : rem;
      paused_n = (mode == RUN) ? ~paused : paused;
    end
    if (mode == RUN && !press[1]) en_n = ~paused_n;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode <= HALT;
      en <= 1'b0;
      busy <= 1'b0;
      paused <= 1'b0;
      rem <= '0;
      count <= '0;
    end else begin
      mode <= mode_n;
      en <= en_n;
      busy <= busy_n;
      paused <= paused_n;
      rem <= rem_n;
      count <= count + CNT_W'(en);
    end
  end
  assign o_cpu_enable = en;
  assign o_mode = mode;
  assign o_busy = busy;
  assign o_paused = paused;
  assign o_cycle_count = count;
endmodule

// File: tb/tb_dbg_step_ctrl.sv
// tb_dbg_step_ctrl: directed-vector bench for dbg_step_ctrl (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
module tb_dbg_step_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_step = 1'b0;
  logic btn_mode = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic en, busy, paused, en4, busy4, paused4;
  logic [1:0] mode, mode4;
  logic [31:0] cnt;
  logic [3:0] cnt4;
  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  dbg_step_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BURST_W(8), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn_step(btn_step), .i_btn_mode(btn_mode),
    .i_burst_len(burst_len), .o_cpu_enable(en), .o_mode(mode), .o_busy(busy),
    .o_paused(paused), .o_cycle_count(cnt));

  // narrow-counter copy sharing all inputs, used for the wrap check
  dbg_step_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BURST_W(8), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_btn_step(btn_step), .i_btn_mode(btn_mode),
    .i_burst_len(burst_len), .o_cpu_enable(en4), .o_mode(mode4), .o_busy(busy4),
    .o_paused(paused4), .o_cycle_count(cnt4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode;
    btn_mode = 1'b1;
    repeat (10) tick();
    btn_mode = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vec++;
    if ({mode, en, busy, paused} !== 5'b0 || cnt !== 32'd0) begin
      err++;
      $display("FAIL reset: got mode=%0d en=%0d busy=%0d paused=%0d cnt=%0d expected all 0", mode, en, busy, paused, cnt);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      vec++;
      if ({mode, en} !== 3'b0 || cnt !== 32'd0) begin
        err++;
        $display("FAIL idle[%0d]: got mode=%0d en=%0d cnt=%0d expected 0/0/0", i, mode, en, cnt);
      end
    end
  endtask

  task automatic test_halt_step;
    int ones = 0;
    btn_step = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == 10) btn_step = 1'b0;
      ones += int'(en);
    end
    vec++;
    if (ones !== 0 || mode !== 2'd0 || cnt !== 32'd0) begin
      err++;
      $display("FAIL halt_step: got en_cycles=%0d mode=%0d cnt=%0d expected 0/0/0", ones, mode, cnt);
    end
  endtask

  task automatic test_debounce;
    press_mode();
    vec++;
    if (mode !== 2'd1) begin
      err++;
      $display("FAIL mode_to_step: got %0d expected 1", mode);
    end
    for (int i = 0; i < 3; i++) begin
      btn_step = 1'b1;
      tick();
      btn_step = 1'b0;
      tick();
    end
    btn_step = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      vec++;
      if (en !== 1'b0) begin
        err++;
        $display("FAIL step_early[%0d]: got en=%0d expected 0", i, en);
      end
    end
    tick();
    vec++;
    if (en !== 1'b1 || cnt !== 32'd0) begin
      err++;
      $display("FAIL step_edge8: got en=%0d cnt=%0d expected 1/0", en, cnt);
    end
    tick();
    vec++;
    if (en !== 1'b0 || cnt !== 32'd1) begin
      err++;
      $display("FAIL step_edge9: got en=%0d cnt=%0d expected 0/1", en, cnt);
    end
    btn_step = 1'b0;
    repeat (12) tick();
    vec++;
    if (en !== 1'b0 || cnt !== 32'd1) begin
      err++;
      $display("FAIL step_settle: got en=%0d cnt=%0d expected 0/1", en, cnt);
    end
  endtask

  task automatic test_burst;
    int ones;
    press_mode();
    vec++;
    if (mode !== 2'd2) begin
      err++;
      $display("FAIL mode_to_burst: got %0d expected 2", mode);
    end
    burst_len = 8'd5;
    btn_step = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 9) burst_len = 8'd9;
      if (i == 10) btn_step = 1'b0;
      vec++;
      if (en !== (i >= 8 && i <= 12) || busy !== (i >= 8 && i <= 12)) begin
        err++;
        $display("FAIL burst5[%0d]: got en=%0d busy=%0d expected %0d", i, en, busy, (i >= 8 && i <= 12));
      end
    end
    vec++;
    if (cnt !== 32'd6) begin
      err++;
      $display("FAIL burst5_cnt: got %0d expected 6", cnt);
    end
    repeat (10) tick();
    burst_len = 8'd20;
    btn_step = 1'b1;
    ones = 0;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (i == 10) btn_step = 1'b0;
      if (i == 18) btn_step = 1'b1;
      if (i == 30) btn_step = 1'b0;
      ones += int'(en);
    end
    repeat (5) tick();
    vec++;
    if (ones !== 20 || cnt !== 32'd26 || busy !== 1'b0) begin
      err++;
      $display("FAIL burst20_repress: got en_cycles=%0d cnt=%0d busy=%0d expected 20/26/0", ones, cnt, busy);
    end
    burst_len = 8'd0;
    btn_step = 1'b1;
    ones = 0;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == 10) btn_step = 1'b0;
      ones += int'(en);
    end
    vec++;
    if (ones !== 1 || cnt !== 32'd27) begin
      err++;
      $display("FAIL burst0: got en_cycles=%0d cnt=%0d expected 1/27", ones, cnt);
    end
  endtask

  task automatic test_abort;
    burst_len = 8'd200;
    btn_step = 1'b1;
    for (int i = 1; i <= 72; i++) begin
      tick();
      if (i == 10) btn_step = 1'b0;
      if (i == 50) btn_mode = 1'b1;
      if (i == 60) btn_mode = 1'b0;
      if (i == 57) begin
        vec++;
        if ({mode, en, busy} !== 4'b1011 || cnt !== 32'd76) begin
          err++;
          $display("FAIL abort_before: got mode=%0d en=%0d busy=%0d cnt=%0d expected 2/1/1/76", mode, en, busy, cnt);
        end
      end
      if (i == 58) begin
        vec++;
        if ({mode, en, busy, paused} !== 5'b11000 || cnt !== 32'd77) begin
          err++;
          $display("FAIL abort_drop: got mode=%0d en=%0d busy=%0d paused=%0d cnt=%0d expected 3/0/0/0/77", mode, en, busy, paused, cnt);
        end
      end
      if (i == 59) begin
        vec++;
        if (en !== 1'b1 || cnt !== 32'd77) begin
          err++;
          $display("FAIL run_entry: got en=%0d cnt=%0d expected 1/77", en, cnt);
        end
      end
    end
    vec++;
    if (en !== 1'b1 || cnt !== 32'd90 || cnt4 !== 4'd10) begin
      err++;
      $display("FAIL run_free: got en=%0d cnt=%0d cnt4=%0d expected 1/90/10", en, cnt, cnt4);
    end
  endtask

  task automatic test_run;
    btn_step = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 10) btn_step = 1'b0;
      if (i == 8 || i == 25) begin
        vec++;
        if ({paused, en} !== 2'b10 || cnt !== 32'd98) begin
          err++;
          $display("FAIL pause[%0d]: got paused=%0d en=%0d cnt=%0d expected 1/0/98", i, paused, en, cnt);
        end
      end
    end
    btn_step = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 10) btn_step = 1'b0;
      if (i == 8) begin
        vec++;
        if ({paused, en} !== 2'b01 || cnt !== 32'd98) begin
          err++;
          $display("FAIL resume: got paused=%0d en=%0d cnt=%0d expected 0/1/98", paused, en, cnt);
        end
      end
    end
    vec++;
    if (en !== 1'b1 || cnt !== 32'd115) begin
      err++;
      $display("FAIL resume_run: got en=%0d cnt=%0d expected 1/115", en, cnt);
    end
    btn_step = 1'b1;
    btn_mode = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == 10) begin
        btn_step = 1'b0;
        btn_mode = 1'b0;
      end
      if (i == 8) begin
        vec++;
        if ({mode, paused, en} !== 4'b0000 || cnt !== 32'd123 || cnt4 !== 4'd11) begin
          err++;
          $display("FAIL simultaneous: got mode=%0d paused=%0d en=%0d cnt=%0d cnt4=%0d expected 0/0/0/123/11", mode, paused, en, cnt, cnt4);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    press_mode();
    press_mode();
    burst_len = 8'd200;
    btn_step = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) btn_step = 1'b0;
    end
    vec++;
    if ({mode, en, busy} !== 4'b1011) begin
      err++;
      $display("FAIL pre_rst_burst: got mode=%0d en=%0d busy=%0d expected 2/1/1", mode, en, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec++;
    if ({mode, en, busy, paused} !== 5'b0 || cnt !== 32'd0 || cnt4 !== 4'd0) begin
      err++;
      $display("FAIL rst_burst: got mode=%0d en=%0d busy=%0d paused=%0d cnt=%0d expected all 0", mode, en, busy, paused, cnt);
    end
    repeat (12) tick();
    press_mode();
    press_mode();
    press_mode();
    vec++;
    if ({mode, en} !== 3'b111) begin
      err++;
      $display("FAIL pre_rst_run: got mode=%0d en=%0d expected 3/1", mode, en);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec++;
    if ({mode, en, busy, paused} !== 5'b0 || cnt !== 32'd0 || {mode4, en4, busy4, paused4} !== 5'b0) begin
      err++;
      $display("FAIL rst_run: got mode=%0d en=%0d busy=%0d paused=%0d cnt=%0d expected all 0", mode, en, busy, paused, cnt);
    end
    repeat (3) tick();
  endtask

  task automatic test_wrap;
    press_mode();
    press_mode();
    btn_mode = 1'b1;
    for (int i = 1; i <= 29; i++) begin
      tick();
      if (i == 10) btn_mode = 1'b0;
    end
    vec++;
    if (cnt4 !== 4'd4 || cnt !== 32'd20 || mode4 !== 2'd3) begin
      err++;
      $display("FAIL wrap: got cnt4=%0d cnt=%0d mode4=%0d expected 4/20/3", cnt4, cnt, mode4);
    end
  endtask

  initial begin
    test_reset();
    test_halt_step();
    test_debounce();
    test_burst();
    test_abort();
    test_run();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/dbg_step_ctrl.md
Name: dbg_step_ctrl

Overview:
- Button-driven execution controller that gates the pipelined CPU's global enable for board-level debugging.
- Supports four modes: HALT, single-STEP, N-cycle BURST and free RUN with pause.
- Includes a metastability synchroniser, a debounce filter and a committed-cycle counter.
- Instantiated between the board push-buttons and the pipeline's enable input; replaces the raw button-to-enable path.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per button input; legal values >= 2.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change; legal values >= 1 (benches use 4).
- BURST_W, 8, width of the burst-length input.
- CNT_W, 32, width of the enabled-cycle counter.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_btn_step  input  1  raw, asynchronous, bouncy step/pause button.
- i_btn_mode  input  1  raw, asynchronous, bouncy mode-select button.
- i_burst_len  input  BURST_W  cycle count for BURST mode; sampled only at the step press.
- o_cpu_enable  output  1  pipeline enable, registered.
- o_mode  output  2  current mode: 0=HALT, 1=STEP, 2=BURST, 3=RUN.
- o_busy  output  1  high while a burst is executing.
- o_paused  output  1  high when in RUN mode and paused.
- o_cycle_count  output  CNT_W  number of cycles in which o_cpu_enable was high; wraps modulo 2^CNT_W.

Behaviour:
- Reset (i_rst high at a clock edge): o_cpu_enable=0, o_mode=0 (HALT), o_busy=0, o_paused=0, o_cycle_count=0. Synchroniser flops, debounced levels, debounce counters and the burst counter all clear to 0. Reset overrides every other event, including mid-burst.
- Synchroniser: each button passes through SYNC_STAGES flops.
- Debounce (one filter per button; db = debounced level):
  - Counter increments while sync output != db.
  - Counter clears to 0 when sync output == db.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still disagreeing, db takes the sync value and the counter clears.
  - db therefore changes after DEBOUNCE_CYCLES consecutive disagreeing cycles.
- Press pulse: a registered, one-cycle pulse on each db rising edge. Falling edges generate nothing.
- Latency: raw button held high from edge k gives its press pulse at edge k+SYNC_STAGES+DEBOUNCE_CYCLES+1. Any resulting o_cpu_enable assertion occurs at the following edge.
- Mode press: o_mode advances 0->1->2->3->0 (wraps).
  - Aborts any active burst: o_busy=0, o_cpu_enable=0.
  - Clears o_paused.
- Step press, by mode:
  - HALT: ignored; o_cpu_enable stays 0.
  - STEP: o_cpu_enable high for exactly one cycle.
  - BURST, not busy: latch i_burst_len, with 0 treated as 1. o_busy and o_cpu_enable go high together for exactly the latched number of cycles, then both drop together.
  - BURST, busy: step press ignored; changes on i_burst_len mid-burst are ignored.
  - RUN: toggles o_paused.
- RUN mode: o_cpu_enable = ~o_paused, registered. On entry to RUN, o_paused=0, so enable goes high on the cycle after the mode change.
- Simultaneous mode and step press pulses in the same cycle: the mode press wins and the step press is discarded.
- o_cycle_count increments on each edge at which o_cpu_enable is currently high; it is never reset by mode changes.

Test Plan:
- Reset, then idle 20 cycles -> o_mode=0, o_cpu_enable=0, o_cycle_count=0 throughout.
- DEBOUNCE_CYCLES=4, SYNC_STAGES=2: one mode press (raw high 10 cycles); bounce step button 1 cycle high / 1 low ×3, then hold high -> exactly one step press; o_cpu_enable high for 1 cycle, first high at edge k+2+4+2 after the stable high; o_cycle_count=1.
- BURST mode with i_burst_len=5: step press -> o_busy and o_cpu_enable high for exactly 5 cycles, o_cycle_count +5. A second step press mid-burst adds nothing. Repeat with i_burst_len=0 -> exactly 1 cycle.
- BURST of 200 cycles, mode press after 50 enabled cycles -> enable drops the cycle after the pulse; o_mode=3; o_cpu_enable re-asserts next cycle (RUN).
- RUN mode: step press -> o_paused=1 and enable 0; step press again -> enable resumes. Force simultaneous mode and step pulses -> o_mode=0 and o_paused=0.
- i_rst asserted mid-burst and in RUN -> all outputs 0 at the next edge. Separately, preload o_cycle_count near 2^CNT_W-1 (CNT_W=4 build, RUN for 20 cycles) -> wraps to 4.
